// File: rtl/reg_dump_pkg.sv
// Shared types and frame constants for the register dump UART.
// Bit-level FSM states and byte/bit terminal counts.
package reg_dump_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } state_t;

  localparam int FRAME_BYTES        = 5;
  localparam int DATA_BITS_PER_BYTE = 8;

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS_PER_BYTE - 1);

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first, registered tx line.
// ready rises on the final stop cycle so a new byte follows with no gap.
module uart_tx_byte
  import reg_dump_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       ready,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          last;

  assign last = (baud == BAUD_LAST);

  // Bit-level state, baud counter, shifter and tx register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  // Next-state: each bit holds for CLKS_PER_BIT cycles.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = tx;
    ready   = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        tx_n  = 1'b1;
        if (load) begin
          state_n = START_BIT;
          tx_n    = 1'b0;
          baud_n  = '0;
          bit_n   = '0;
          shift_n = data_in;
        end
      end
      START_BIT: begin
        if (last) begin
          state_n = DATA_BITS;
          tx_n    = shift[0];
          baud_n  = '0;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA_BITS: begin
        if (last) begin
          baud_n = '0;
          if (bit_cnt == LAST_BIT) begin
            state_n = STOP_BIT;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_cnt + 3'd1;
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP_BIT: begin
        if (last) begin
          ready  = 1'b1;
          baud_n = '0;
          if (load) begin
            state_n = START_BIT;
            tx_n    = 1'b0;
            bit_n   = '0;
            shift_n = data_in;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/reg_dump_uart.sv
// Snapshots reg1..reg4 on start and sends HEADER + 4 bytes over UART.
// Owns frame sequencing, busy and the one-cycle done pulse.
module reg_dump_uart
  import reg_dump_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] reg1,
  input  logic [7:0] reg2,
  input  logic [7:0] reg3,
  input  logic [7:0] reg4,
  input  logic       start,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  logic [7:0] snap [FRAME_BYTES];
  logic [2:0] idx;
  logic       load;
  logic [7:0] data_in;
  logic       ready;

  // Byte feed: header on accept, next snapshot byte as each stop ends.
  always_comb begin
    load    = 1'b0;
    data_in = HEADER;
    if (!busy) begin
      load = start;
    end else if (ready && idx != LAST_BYTE) begin
      load    = 1'b1;
      data_in = snap[idx + 3'd1];
    end
  end

  // Frame control: capture, byte index, busy and done.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      idx  <= '0;
      for (int i = 0; i < FRAME_BYTES; i++) snap[i] <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          snap[0] <= HEADER;
          snap[1] <= reg1;
          snap[2] <= reg2;
          snap[3] <= reg3;
          snap[4] <= reg4;
          busy    <= 1'b1;
          idx     <= '0;
        end
      end else if (ready) begin
        if (idx == LAST_BYTE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          idx <= idx + 3'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .data_in(data_in),
    .ready  (ready),
    .tx     (tx)
  );

endmodule

// File: doc/reg_dump_uart.md
Name: reg_dump_uart

Overview:
- Downstream consumer of the final_project datapath: takes the four 8-bit architectural register outputs reg1..reg4 and serialises a snapshot of them over a UART TX line (8N1, LSB first) for board-level observation.
- On a start request it captures all four registers in the same cycle, then transmits a 5-byte frame: HEADER, reg1, reg2, reg3, reg4.
- Sits beside the final_project top, fed directly by its reg1..reg4 wires; tx goes to the board UART pin.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2; benches use 4.
- HEADER, 8'hA5, sync byte sent first in every frame.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- reg1  input  8  register 1 value from datapath.
- reg2  input  8  register 2 value.
- reg3  input  8  register 3 value.
- reg4  input  8  register 4 value.
- start  input  1  frame request; sampled each rising edge.
- tx  output  1  UART serial line, idle high, registered.
- busy  output  1  high while a frame is in progress, registered.
- done  output  1  one-cycle pulse at frame completion, registered.

Behaviour:
- Reset values: tx=1, busy=0, done=0, state=IDLE, bit and byte counters=0, snapshot registers=0.
- Reset is synchronous and has priority over everything. Reset mid-frame aborts the frame: tx=1 from that edge, no done pulse.
- FSM states: IDLE, START_BIT, DATA_BITS, STOP_BIT.
- IDLE: tx=1. If start=1 at edge k:
  - snap[0..4] <= {HEADER, reg1, reg2, reg3, reg4};
  - state <= START_BIT, tx <= 0, busy <= 1, byte index <= 0, baud counter <= 0.
- Bit timing: every bit, including start and stop, drives tx for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and advances the bit on the terminal count.
- START_BIT -> DATA_BITS: drive data bits 0..7 of snap[byte index], LSB first.
- DATA_BITS -> STOP_BIT: tx=1 for CLKS_PER_BIT cycles.
- STOP_BIT end:
  - If byte index < 4: increment the index, go to START_BIT with tx <= 0 on the same edge. There are no idle cycles between bytes within a frame.
  - If byte index == 4: state <= IDLE, busy <= 0, done <= 1 for exactly one cycle.
- Frame length: tx falls at edge k; busy stays high for exactly 50*CLKS_PER_BIT cycles; done is asserted in the first cycle busy is low.
- start while busy=1 is ignored, not queued. Register inputs changing mid-frame do not affect the frame, because the data was snapshotted.
- start=1 during the done cycle (state is IDLE) is accepted. With start held high, consecutive frames are separated by exactly one extra idle-high cycle (stop period CLKS_PER_BIT+1 cycles).
- Counter widths: baud counter $clog2(CLKS_PER_BIT), bit counter 3 bits, byte index 3 bits. No counter wraps past its terminal value.

Decomposition:
- Shared package reg_dump_pkg:
  - state enum {IDLE, START_BIT, DATA_BITS, STOP_BIT};
  - localparam FRAME_BYTES=5, DATA_BITS_PER_BYTE=8.
- One sub-module is natural: uart_tx_byte (baud counter + shift register; load/data_in/ready/tx).
  - reg_dump_uart holds the snapshot, byte sequencing, busy and done.
  - uart_tx_byte must accept a new load on the same cycle its stop bit completes, so bytes stay contiguous.

Test Plan:
- Basic frame: CLKS_PER_BIT=4, reg1..reg4=12,34,56,78 hex, 1-cycle start pulse -> decoded bytes A5,12,34,56,78; tx low 1 cycle after the start edge; busy high exactly 200 cycles; single done pulse.
- Snapshot: start with reg1=0x12, change reg1 to 0xFF one cycle later -> second byte still 0x12.
- Ignored start: pulse start again 30 cycles into the frame -> no extra frame; busy 200 cycles total; one done.
- Back-to-back: start held high for 450 cycles -> two full frames plus a third in progress; tx high for 5 cycles (4+1) between frame 1 stop start and frame 2 start bit; done pulses at cycles 200 and 401 relative to first acceptance.
- Reset mid-frame: assert reset for 1 cycle at cycle 60 of a frame -> tx=1, busy=0 from that edge; no done; a subsequent start yields a clean full frame.
- Boundary data: reg values 00,FF,55,AA -> bit-exact waveform check of all 50 bit periods, LSB first, stop bits high.
